xlr8_text_render: RTL and testbench
===================================

Name: xlr8_text_render

Overview:
- Pixel-side consumer of the character/attribute dual-port RAMs.
- Generates 640x480@60 timing and fetches char/attr bytes for each 8x16 cell through RAM port B, then looks up the glyph row in an external font ROM.
- Produces 24-bit RGB plus syncs and DE for the TMDS encoder.
- Supports hardware scrolling via row_offset and attribute blink.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (ticks)
- H_SYNC, 96, hsync width (ticks)
- H_BP, 48, horizontal back porch (ticks)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- COLS, 80, text columns
- ROWS, 30, text rows

Ports:
- clk_pixel  in  1  pixel-domain clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel tick enable (1 in 10 clk_pixel cycles); all state advances only when high
- row_offset  in  8  scroll offset in text rows
- ram_address  out  13  shared char/attr RAM port-B address
- ram_re  out  1  char/attr read enable
- ram_char_data  in  8  char RAM q_b; 1-clock latency, held while re low
- ram_attr_data  in  8  attr RAM q_b; same timing as ram_char_data
- font_address  out  12  {char[7:0], glyph_row[3:0]}
- font_re  out  1  font ROM read enable
- font_data  in  8  glyph row; bit7 = leftmost pixel; 1-clock latency, held while re low
- red  out  8  pixel red
- green  out  8  pixel green
- blue  out  8  pixel blue
- hsync  out  1  active-low horizontal sync
- vsync  out  1  active-low vertical sync
- de  out  1  active video
- frame_start  out  1  one-clk pulse on the pix_en tick where h=0, v=0

Behaviour:
- Reset values:
  - h, v counters = 0; frame counter = 0; blink = 0.
  - red/green/blue = 0, hsync = 1, vsync = 1, de = 0.
  - ram_re = 0, font_re = 0, frame_start = 0, addresses = 0.
  - Reset mid-frame restarts at h=0, v=0 on the next tick; no partial pipeline data is emitted.
- Counters:
  - h counts 0..799 and wraps to 0; v increments on h wrap and counts 0..524 (wraps).
  - Internal hsync low for h in 656..751; internal vsync low for v in 490..491; internal de = (h<640 && v<480).
- Scroll offset:
  - row_offset is sampled only at frame_start; the effective offset is row_offset if <30, else 0.
  - Changes mid-frame take effect at the next frame.
- Fetch pipeline (all stages counted in pix_en ticks):
  - T0: internal de && h[2:0]==0. Assert ram_re for that single clk_pixel cycle with ram_address = mem_row*80 + h[9:3], where mem_row = (v[8:4] + eff_offset) mod 30. Address range 0..2399.
  - T1: latch char and attr. Assert font_re for one cycle with font_address = {char, v[3:0]}.
  - T2: latch font_data into the pixel shift register, together with the cell's attr.
  - T3: registered outputs.
  - hsync, vsync, de and RGB are delayed by exactly 3 ticks relative to the internal counters. The shift register is indexed by the delayed h[2:0], so bit7 is shown first.
- Colour:
  - attr[3:0] = foreground index, attr[6:4] = background index (0..7), attr[7] = blink.
  - Pixel uses the foreground index if the glyph bit = 1 and !(attr[7] && blink); otherwise it uses the background index.
- Palette (CGA), index i:
  - Each component = 0xAA*base + 0x55*i[3], where base is i[2] for R, i[1] for G, i[0] for B.
  - Exception: index 6 G = 0x55.
  - Examples: 0x0 = 000000, 0x1 = 0000AA, 0x7 = AAAAAA, 0x8 = 555555, 0xF = FFFFFF.
- Output blanking: when delayed de = 0, RGB = 0.
- Blink:
  - The 6-bit frame counter increments at each frame_start and wraps at 63 to 0.
  - blink = counter[5], so blink is 0 for frames 0..31 and 1 for frames 32..63.
- ram_re and font_re are never asserted outside T0/T1 cycles, and never while rst.

Test Plan:
1. Reset: hold rst 5 cycles with pix_en toggling -> hsync=1, vsync=1, de=0, RGB=0, ram_re=0, font_re=0; the first frame_start occurs on the first pix_en tick after release.
2. Timing:
   - Count ticks over 2 frames -> line = 800 ticks, hsync low 96 ticks starting 656+3 ticks after line start.
   - Frame = 525 lines, vsync low on lines 490-491.
   - de high for exactly 640x480 ticks per frame; frame_start period = 420000 ticks.
3. Addressing:
   - row_offset=0 -> first read address 0, line 16 first address 80, last address 2399 on line 479 col 79.
   - row_offset=29 -> line 0 reads 2320, line 16 reads 0.
   - row_offset=45 -> line 0 reads 0.
4. Pixel path: addr0 char=0x41 attr=0x1F, font(0x41,row0)=0x81 -> output pixels 0..7 of line 0 = FFFFFF, then 0000AA x6, then FFFFFF; pixel 0 appears 3 ticks after h=0.
5. Blink: attr=0x8F, font=0xFF -> pixel FFFFFF in frames 0..31, 000000 in frames 32..63, FFFFFF again at frame 64.
6. Mid-operation:
   - Change row_offset 0->1 at line 100 -> reads unchanged until the next frame_start, then line 0 reads 80.
   - Assert rst at h=300, v=200 -> outputs return to reset values, counters restart at 0.

Source files
------------

// File: rtl/xlr8_text_render.sv
// Text-mode renderer: 640x480 timing, char/attr fetch over RAM port B, font lookup, CGA colour.
// Syncs, DE and RGB trail the internal h/v counters by exactly three pix_en ticks.
module xlr8_text_render #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int COLS     = 80,
  parameter int ROWS     = 30
) (
  input  logic        clk_pixel,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [7:0]  row_offset,
  output logic [12:0] ram_address,
  output logic        ram_re,
  input  logic [7:0]  ram_char_data,
  input  logic [7:0]  ram_attr_data,
  output logic [11:0] font_address,
  output logic        font_re,
  input  logic [7:0]  font_data,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start
);

  localparam logic [9:0]  H_TOT  = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam logic [9:0]  H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0]  HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0]  HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0]  V_TOT  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0]  V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0]  VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0]  VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [5:0]  ROWS_W = 6'(ROWS);
  localparam logic [7:0]  ROWS_B = 8'(ROWS);
  localparam logic [12:0] COLS_W = 13'(COLS);

  logic [9:0]  h_q, h_d, v_q, v_d;
  logic [4:0]  off_q, off_samp, off_eff;
  logic [5:0]  frame_cnt_q;
  logic        fetch1_q;
  logic [3:0]  vrow1_q;
  logic [7:0]  attr1_q;
  logic        de1_q, hs1_q, vs1_q, de2_q, hs2_q, vs2_q;
  logic [2:0]  hx1_q, hx2_q;
  logic [7:0]  glyph_q, attr2_q;
  logic        de_q, hsync_q, vsync_q;
  logic [23:0] rgb_q;

  logic        h_last, v_last, fs_pos, de_int, hs_int, vs_int, t0;
  logic [5:0]  row_sum, mem_row;
  logic [12:0] addr_calc;
  logic [7:0]  cur_glyph, cur_attr;
  logic        pix_on;
  logic [3:0]  pix_idx;
  logic [23:0] pix_rgb;

  function automatic logic [23:0] cga(input logic [3:0] idx);
    logic [7:0] hi, r, g, b;
    hi = idx[3] ? 8'h55 : 8'h00;
    r  = (idx[2] ? 8'hAA : 8'h00) + hi;
    g  = (idx == 4'd6) ? 8'h55 : (idx[1] ? 8'hAA : 8'h00) + hi;
    b  = (idx[0] ? 8'hAA : 8'h00) + hi;
    return {r, g, b};
  endfunction

  always_comb begin
    h_last    = (h_q == H_TOT - 10'd1);
    v_last    = (v_q == V_TOT - 10'd1);
    h_d       = h_last ? 10'd0 : h_q + 10'd1;
    v_d       = h_last ? (v_last ? 10'd0 : v_q + 10'd1) : v_q;
    fs_pos    = (h_q == 10'd0) && (v_q == 10'd0);
    de_int    = (h_q < H_ACT) && (v_q < V_ACT);
    hs_int    = !((h_q >= HS_BEG) && (h_q < HS_END));
    vs_int    = !((v_q >= VS_BEG) && (v_q < VS_END));
    t0        = de_int && (h_q[2:0] == 3'd0);
    // The frame-start tick already fetches, so it must see the freshly sampled offset.
    off_samp  = (row_offset < ROWS_B) ? row_offset[4:0] : 5'd0;
    off_eff   = fs_pos ? off_samp : off_q;
    row_sum   = {1'b0, v_q[8:4]} + {1'b0, off_eff};
    mem_row   = (row_sum >= ROWS_W) ? row_sum - ROWS_W : row_sum;
    addr_calc = 13'(mem_row) * COLS_W + 13'(h_q[9:3]);
    // First pixel of a cell takes glyph/attr straight from the fetch path.
    cur_glyph = (hx2_q == 3'd0) ? font_data : glyph_q;
    cur_attr  = (hx2_q == 3'd0) ? attr1_q : attr2_q;
    pix_on    = cur_glyph[3'd7 - hx2_q] && !(cur_attr[7] && frame_cnt_q[5]);
    pix_idx   = pix_on ? cur_attr[3:0] : {1'b0, cur_attr[6:4]};
    pix_rgb   = cga(pix_idx);
  end

  assign ram_re       = pix_en && !rst && t0;
  assign ram_address  = ram_re ? addr_calc : 13'd0;
  assign font_re      = pix_en && !rst && fetch1_q;
  assign font_address = font_re ? {ram_char_data, vrow1_q} : 12'd0;
  assign frame_start  = pix_en && !rst && fs_pos;

  assign de    = de_q;
  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign red   = rgb_q[23:16];
  assign green = rgb_q[15:8];
  assign blue  = rgb_q[7:0];

  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      h_q         <= 10'd0;
      v_q         <= 10'd0;
      off_q       <= 5'd0;
      frame_cnt_q <= 6'd0;
      fetch1_q    <= 1'b0;
      vrow1_q     <= 4'd0;
      attr1_q     <= 8'd0;
      de1_q       <= 1'b0;
      hs1_q       <= 1'b1;
      vs1_q       <= 1'b1;
      hx1_q       <= 3'd0;
      de2_q       <= 1'b0;
      hs2_q       <= 1'b1;
      vs2_q       <= 1'b1;
      hx2_q       <= 3'd0;
      glyph_q     <= 8'd0;
      attr2_q     <= 8'd0;
      de_q        <= 1'b0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      rgb_q       <= 24'd0;
    end else if (pix_en) begin
      h_q <= h_d;
      v_q <= v_d;
      if (fs_pos) off_q <= off_samp;
      // Counting on the last tick of a frame keeps frame 0 after reset at count 0.
      if (h_last && v_last) frame_cnt_q <= frame_cnt_q + 6'd1;
      fetch1_q <= t0;
      vrow1_q  <= v_q[3:0];
      if (fetch1_q) attr1_q <= ram_attr_data;
      de1_q <= de_int;
      hs1_q <= hs_int;
      vs1_q <= vs_int;
      hx1_q <= h_q[2:0];
      de2_q <= de1_q;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
      hx2_q <= hx1_q;
      if (de2_q && hx2_q == 3'd0) begin
        glyph_q <= font_data;
        attr2_q <= attr1_q;
      end
      de_q    <= de2_q;
      hsync_q <= hs2_q;
      vsync_q <= vs2_q;
      rgb_q   <= de2_q ? pix_rgb : 24'd0;
    end
  end

endmodule

// File: tb/tb_xlr8_text_render.sv
// Directed bench for xlr8_text_render on a shrunken raster (16x32 active, 20x35 total).
// RAM and font ROM are behavioural 1-clock-latency models that hold data while re is low.
module tb_xlr8_text_render;

  localparam int HA = 16, HF = 1, HS = 2, HB = 1;
  localparam int VA = 32, VF = 1, VS = 1, VB = 1;
  localparam int NC = 2, NR = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;

  logic        clk_pixel = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic [7:0]  row_offset = 8'd0;
  logic [12:0] ram_address;
  logic        ram_re;
  logic [7:0]  ram_char_data = 8'd0;
  logic [7:0]  ram_attr_data = 8'd0;
  logic [11:0] font_address;
  logic        font_re;
  logic [7:0]  font_data = 8'd0;
  logic [7:0]  red, green, blue;
  logic        hsync, vsync, de, frame_start;

  xlr8_text_render #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .COLS(NC), .ROWS(NR)
  ) dut (
    .clk_pixel(clk_pixel), .rst(rst), .pix_en(pix_en), .row_offset(row_offset),
    .ram_address(ram_address), .ram_re(ram_re),
    .ram_char_data(ram_char_data), .ram_attr_data(ram_attr_data),
    .font_address(font_address), .font_re(font_re), .font_data(font_data),
    .red(red), .green(green), .blue(blue),
    .hsync(hsync), .vsync(vsync), .de(de), .frame_start(frame_start)
  );

  always #5 clk_pixel = ~clk_pixel;

  logic [7:0] char_mem [4];
  logic [7:0] attr_mem [4];
  logic [7:0] font_mem [4096];

  always @(posedge clk_pixel) begin
    if (ram_re) begin
      ram_char_data <= char_mem[ram_address[1:0]];
      ram_attr_data <= attr_mem[ram_address[1:0]];
    end
    if (font_re) font_data <= font_mem[font_address];
  end

  typedef struct {
    logic [7:0]  chr;
    logic [7:0]  attr;
    logic [7:0]  glyph;
    logic [23:0] fg;
    logic [23:0] bg;
  } vec_t;

  typedef struct {
    logic [7:0] off;
    int         a0;
    int         a16;
  } off_t;

  int checks = 0;
  int errors = 0;
  int tk;
  logic [23:0] s_rgb;
  logic s_hs, s_vs, s_de, s_re, s_fre, s_fs;
  int s_addr, s_faddr;
  int de_cnt, hs_lo, vs_lo, fs_cnt, fs_bad, re_cnt, fre_cnt, blank_bad, idle_bad;
  int first_hs, first_vs, first_de, last_de, last_addr, last_addr_pos;
  int line_addr [VT];
  logic [23:0] pix0 [70];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear_stats();
    de_cnt = 0; hs_lo = 0; vs_lo = 0; fs_cnt = 0; fs_bad = 0;
    re_cnt = 0; fre_cnt = 0; blank_bad = 0; idle_bad = 0;
    first_hs = -1; first_vs = -1; first_de = -1; last_de = -1;
    last_addr = -1; last_addr_pos = -1;
    for (int i = 0; i < VT; i++) line_addr[i] = -1;
  endtask

  task automatic tick(input int gap);
    int pos, ln, hh;
    @(negedge clk_pixel);
    pix_en = 1'b1;
    #1;
    s_rgb = {red, green, blue};
    s_hs = hsync; s_vs = vsync; s_de = de; s_fs = frame_start;
    s_re = ram_re; s_addr = int'(ram_address);
    s_fre = font_re; s_faddr = int'(font_address);
    pos = tk % FT; ln = pos / HT; hh = pos % HT;
    if (s_re) begin
      re_cnt++;
      if (hh == 0) line_addr[ln] = s_addr;
      if (tk < FT) begin last_addr = s_addr; last_addr_pos = pos; end
    end
    if (s_fre) fre_cnt++;
    if (s_fs) begin fs_cnt++; if (pos != 0) fs_bad++; end
    if (s_de) begin
      de_cnt++;
      if (first_de < 0) first_de = pos;
      last_de = pos;
    end else if (s_rgb != 24'h0) blank_bad++;
    if (!s_hs) begin hs_lo++; if (first_hs < 0) first_hs = pos; end
    if (!s_vs) begin vs_lo++; if (first_vs < 0) first_vs = pos; end
    if (pos == 3 && tk / FT < 70) pix0[tk / FT] = s_rgb;
    tk++;
    for (int i = 0; i < gap; i++) begin
      @(negedge clk_pixel);
      pix_en = 1'b0;
      #1;
      if (ram_re || font_re || frame_start) idle_bad++;
    end
  endtask

  task automatic do_reset(input int n);
    @(negedge clk_pixel);
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      pix_en = i[0];
      @(negedge clk_pixel);
    end
    rst = 1'b0;
    pix_en = 1'b0;
    tk = 0;
    clear_stats();
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " hsync"}, 32'(hsync), 32'd1);
    chk({tag, " vsync"}, 32'(vsync), 32'd1);
    chk({tag, " de"}, 32'(de), 32'd0);
    chk({tag, " rgb"}, 32'({red, green, blue}), 32'd0);
    chk({tag, " ram_re"}, 32'(ram_re), 32'd0);
    chk({tag, " font_re"}, 32'(font_re), 32'd0);
    chk({tag, " frame_start"}, 32'(frame_start), 32'd0);
    chk({tag, " ram_address"}, 32'(ram_address), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs [8];
    off_t offs [4];
    vec_t v;
    int bad_rst;
    vecs[0] = '{8'h41, 8'h1F, 8'h81, 24'hFFFFFF, 24'h0000AA};
    vecs[1] = '{8'h42, 8'h60, 8'h0F, 24'h000000, 24'hAA5500};
    vecs[2] = '{8'h43, 8'h7E, 8'hAA, 24'hFFFF55, 24'hAAAAAA};
    vecs[3] = '{8'h44, 8'h38, 8'hF0, 24'h555555, 24'h00AAAA};
    vecs[4] = '{8'h45, 8'h45, 8'h3C, 24'hAA00AA, 24'hAA0000};
    vecs[5] = '{8'h46, 8'h2C, 8'h01, 24'hFF5555, 24'h00AA00};
    vecs[6] = '{8'h47, 8'h5B, 8'hC3, 24'h55FFFF, 24'hAA00AA};
    vecs[7] = '{8'h48, 8'h09, 8'h5A, 24'h5555FF, 24'h000000};
    offs[0] = '{8'd0,  0, 2};
    offs[1] = '{8'd1,  2, 0};
    offs[2] = '{8'd2,  0, 2};
    offs[3] = '{8'd45, 0, 2};

    for (int i = 0; i < 4; i++) begin char_mem[i] = 8'h41; attr_mem[i] = 8'h1F; end
    for (int i = 0; i < 4096; i++) font_mem[i] = 8'h81;
    tk = 0;
    clear_stats();

    // Reset held 5 cycles with pix_en toggling
    bad_rst = 0;
    @(negedge clk_pixel);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pix_en = i[0];
      @(negedge clk_pixel);
      #1;
      if (ram_re || font_re || frame_start) bad_rst++;
    end
    pix_en = 1'b1;
    #1;
    chk_reset_outputs("reset");
    chk("re during reset", 32'(bad_rst), 32'd0);
    rst = 1'b0;
    pix_en = 1'b0;
    tk = 0;
    clear_stats();
    tick(0);
    chk("first frame_start", 32'(s_fs), 32'd1);
    chk("first ram_re", 32'(s_re), 32'd1);
    chk("first ram_address", 32'(s_addr), 32'd0);

    // Two frames of raster timing
    while (tk < 2 * FT + 3) tick(0);
    chk("de ticks 2 frames", 32'(de_cnt), 32'(2 * HA * VA));
    chk("hsync low ticks", 32'(hs_lo), 32'(2 * VT * HS));
    chk("vsync low ticks", 32'(vs_lo), 32'(2 * VS * HT));
    chk("frame_start count", 32'(fs_cnt), 32'd3);
    chk("frame_start misplaced", 32'(fs_bad), 32'd0);
    chk("ram_re count", 32'(re_cnt), 32'(2 * (HA / 8) * VA + 1));
    chk("font_re count", 32'(fre_cnt), 32'(2 * (HA / 8) * VA + 1));
    chk("first de pos", 32'(first_de), 32'd3);
    chk("last de pos", 32'(last_de), 32'((VA - 1) * HT + HA - 1 + 3));
    chk("first hsync low pos", 32'(first_hs), 32'(HA + HF + 3));
    chk("first vsync low pos", 32'(first_vs), 32'((VA + VF) * HT + 3));
    chk("blanking rgb", 32'(blank_bad), 32'd0);
    chk("line0 addr off0", 32'(line_addr[0]), 32'd0);
    chk("line16 addr off0", 32'(line_addr[16]), 32'(NC));
    chk("last addr", 32'(last_addr), 32'(NC * NR - 1));
    chk("last addr pos", 32'(last_addr_pos), 32'((VA - 1) * HT + 8));

    // Scroll offsets, including saturation of out-of-range values
    for (int i = 0; i < 4; i++) begin
      row_offset = offs[i].off;
      do_reset(2);
      while (tk < FT) tick(0);
      chk($sformatf("line0 addr off%0d", offs[i].off), 32'(line_addr[0]), 32'(offs[i].a0));
      chk($sformatf("line16 addr off%0d", offs[i].off), 32'(line_addr[16]), 32'(offs[i].a16));
    end
    row_offset = 8'd0;

    // Pixel path vectors, pix_en one tick in three cycles
    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      for (int k = 0; k < 4; k++) begin char_mem[k] = v.chr; attr_mem[k] = v.attr; end
      for (int r = 0; r < 16; r++) font_mem[{v.chr, 4'(r)}] = v.glyph;
      do_reset(2);
      for (int t = 0; t <= 10; t++) begin
        tick(2);
        if (t == 1) begin
          chk($sformatf("v%0d font_re", i), 32'(s_fre), 32'd1);
          chk($sformatf("v%0d font_addr", i), 32'(s_faddr), 32'({v.chr, 4'h0}));
        end
        if (t == 2) chk($sformatf("v%0d de early", i), 32'(s_de), 32'd0);
        if (t >= 3)
          chk($sformatf("v%0d pixel%0d", i, t - 3), 32'(s_rgb),
              32'(v.glyph[10 - t] ? v.fg : v.bg));
      end
    end
    chk("re while pix_en low", 32'(idle_bad), 32'd0);

    // Blink over 65 frames
    for (int k = 0; k < 4; k++) begin char_mem[k] = 8'h50; attr_mem[k] = 8'h8F; end
    for (int r = 0; r < 16; r++) font_mem[{8'h50, 4'(r)}] = 8'hFF;
    do_reset(2);
    while (tk < 65 * FT) tick(0);
    chk("blink frame0", 32'(pix0[0]), 32'hFFFFFF);
    chk("blink frame31", 32'(pix0[31]), 32'hFFFFFF);
    chk("blink frame32", 32'(pix0[32]), 32'h000000);
    chk("blink frame63", 32'(pix0[63]), 32'h000000);
    chk("blink frame64", 32'(pix0[64]), 32'hFFFFFF);

    // row_offset change mid-frame waits for the next frame_start
    for (int k = 0; k < 4; k++) begin char_mem[k] = 8'h41; attr_mem[k] = 8'h70; end
    row_offset = 8'd0;
    do_reset(2);
    while (tk < 10 * HT) tick(0);
    row_offset = 8'd1;
    while (tk < FT) tick(0);
    chk("midframe line0", 32'(line_addr[0]), 32'd0);
    chk("midframe line16", 32'(line_addr[16]), 32'(NC));
    while (tk < 2 * FT) tick(0);
    chk("nextframe line0", 32'(line_addr[0]), 32'(NC));
    chk("nextframe line16", 32'(line_addr[16]), 32'd0);

    // Reset in the middle of active video
    row_offset = 8'd0;
    do_reset(2);
    while (tk < 20 * HT + 5) tick(0);
    chk("pre-reset de", 32'(s_de), 32'd1);
    @(negedge clk_pixel);
    rst = 1'b1;
    pix_en = 1'b1;
    @(negedge clk_pixel);
    #1;
    chk_reset_outputs("midreset");
    rst = 1'b0;
    pix_en = 1'b0;
    tk = 0;
    clear_stats();
    tick(0);
    chk("restart frame_start", 32'(s_fs), 32'd1);
    chk("restart ram_re", 32'(s_re), 32'd1);
    chk("restart ram_address", 32'(s_addr), 32'd0);
    while (tk < FT) tick(0);
    chk("restart first de", 32'(first_de), 32'd3);
    chk("restart de ticks", 32'(de_cnt), 32'(HA * VA));
    chk("restart blanking", 32'(blank_bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
